cmp_minmax_seq: RTL
===================

// Module: cmp_minmax_seq
// PURPOSE
//  Sequencer that shares one external 8-bit magnitude comparator (gt/eq/lt outputs) to find the
//  max and min of a burst of up to DEPTH operands. Operands stream in over valid/ready and are
//  buffered. One comparison is issued per cycle. Result is held on a valid/ready output port.
//  Sits between an operand source and the combinational comparator datapath.
// PARAMETERS
//  DATA_W  8  operand width; must match comparator width
//  DEPTH   8  max operands per burst (>=2); IDX_W=$clog2(DEPTH), CNT_W=$clog2(DEPTH+1)
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       reset, asynchronous, active-low
//  in_valid     in   1       operand valid
//  in_ready     out  1       block accepts operand (LOAD state only)
//  in_data      in   DATA_W  operand, unsigned
//  in_last      in   1       last operand of burst
//  cmp_a        out  DATA_W  comparator operand A (candidate)
//  cmp_b        out  DATA_W  comparator operand B (current best)
//  cmp_gt       in   1       A>B from comparator, combinational same cycle
//  cmp_eq       in   1       A==B
//  cmp_lt       in   1       A<B
//  out_valid    out  1       result valid, held until taken
//  out_ready    in   1       consumer takes result
//  out_max      out  DATA_W  maximum value
//  out_min      out  DATA_W  minimum value
//  out_max_idx  out  IDX_W   arrival index of max (first occurrence)
//  out_min_idx  out  IDX_W   arrival index of min (first occurrence)
//  out_count    out  CNT_W   operands in burst (1..DEPTH)
//  cmp_err      out  1       sticky: comparator flags not one-hot during a scan
// BEHAVIOUR
//  Reset (async, rst_n=0): state LOAD; count=0; all outputs 0 except in_ready=1; cmp_err=0.
//  FSM: LOAD -> SCAN_MAX -> SCAN_MIN -> DONE -> LOAD.
//  LOAD: in_ready=1. Handshake in_valid&in_ready writes buf[count], count++.
//   Burst ends on an accept with in_last=1, or on the accept that fills DEPTH (in_last implied).
//   End with N=1: go to DONE, max=min=buf[0], idx=0. Otherwise go to SCAN_MAX with best=buf[0], idx=0, i=1.
//  SCAN_MAX: cmp_a=buf[i], cmp_b=best_max. If cmp_gt: best_max<=buf[i], max_idx<=i.
//   i++. After i==N-1, go to SCAN_MIN with best_min=buf[0], min_idx=0, i=1.
//  SCAN_MIN: same, but update on cmp_lt. After i==N-1, go to DONE.
//  Ties (cmp_eq) never update, so the lowest index wins.
//  Outside the SCAN states, cmp_a=cmp_b=0 and comparator flags are ignored.
//  In SCAN states, if (cmp_gt+cmp_eq+cmp_lt)!=1, set cmp_err (stays set until reset). Scan continues.
//   In that case, update only on the flag named above.
//  Latency: out_valid rises on the (2N-1)th clk edge after the edge accepting the last operand.
//  DONE: out_valid=1. All out_* values are stable while out_valid=1.
//   out_valid&out_ready -> LOAD next edge: count=0, out_valid=0. out_* keep last values.
//  in_ready=0 in SCAN/DONE. in_valid there is ignored (no drop: source must hold).
//  rst_n low at any point aborts the burst. Outputs return to reset values immediately.
// TESTING
//  1 reset: rst_n=0 mid-SCAN_MAX -> out_valid=0, in_ready=1, count=0, cmp_a=0 same cycle
//  2 burst {8,7,100,64,32} last on 32 -> max=100 idx2, min=7 idx1, count=5, out_valid 9 edges after
//  3 single {55} with last -> max=min=55, idx 0/0, out_valid 1 edge after accept
//  4 ties {32,120,32,120,0,0} -> max=120 idx1, min=0 idx4 (first occurrence)
//  5 DEPTH=8 values {1..8}, in_last never set -> burst closes on 8th, count=8, max=8 idx7, min=1 idx0
//  6 out_ready=0 for 5 cycles -> outputs stable, in_ready=0. Faulty comparator forcing gt=eq=1 -> cmp_err=1

Source files
------------

// File: rtl/cmp_minmax_seq.sv
`default_nettype none
// ============================================================================
// Module   : cmp_minmax_seq
// Summary  : Buffers an operand burst and finds its max/min (value and first
//            index) using one shared external magnitude comparator.
// Revision : 1.0 - initial release
// ============================================================================
module cmp_minmax_seq #(
    parameter int  DATA_W = 8,
    parameter int  DEPTH  = 8,
    localparam int IDX_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic [DATA_W-1:0] cmp_a,
    output logic [DATA_W-1:0] cmp_b,
    input  logic              cmp_gt,
    input  logic              cmp_eq,
    input  logic              cmp_lt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_max,
    output logic [DATA_W-1:0] out_min,
    output logic [IDX_W-1:0]  out_max_idx,
    output logic [IDX_W-1:0]  out_min_idx,
    output logic [CNT_W-1:0]  out_count,
    output logic              cmp_err
);

    typedef enum logic [1:0] {
        S_LOAD     = 2'd0,
        S_SCAN_MAX = 2'd1,
        S_SCAN_MIN = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_fill = CNT_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] c_idx_one  = IDX_W'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_buf [DEPTH];
    logic [CNT_W-1:0]  r_count;
    logic [IDX_W-1:0]  r_i;
    logic [DATA_W-1:0] r_best_max;
    logic [DATA_W-1:0] r_best_min;
    logic [IDX_W-1:0]  r_max_idx;
    logic [IDX_W-1:0]  r_min_idx;
    logic              r_out_valid;
    logic              r_cmp_err;

    logic              w_accept;
    logic              w_burst_end;
    logic              w_scan_end;
    logic              w_scanning;
    logic              w_flags_bad;
    logic [DATA_W-1:0] w_cand;

    assign w_accept    = in_valid && (r_state == S_LOAD);
    // A burst closes on in_last or on the accept that fills the buffer.
    assign w_burst_end = w_accept && (in_last || (r_count == c_cnt_fill));
    assign w_cand      = r_buf[r_i];
    assign w_scan_end  = (CNT_W'(r_i) == (r_count - c_cnt_one));
    assign w_scanning  = (r_state == S_SCAN_MAX) || (r_state == S_SCAN_MIN);
    assign w_flags_bad = !$onehot({cmp_gt, cmp_eq, cmp_lt});

    assign out_valid = r_out_valid;
    assign cmp_err   = r_cmp_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        cmp_a       = '0;
        cmp_b       = '0;
        case (r_state)
            S_LOAD: begin
                in_ready = 1'b1;
                if (w_burst_end) begin
                    w_state_nxt = (r_count == '0) ? S_DONE : S_SCAN_MAX;
                end
            end
            S_SCAN_MAX: begin
                cmp_a = w_cand;
                cmp_b = r_best_max;
                if (w_scan_end) begin
                    w_state_nxt = S_SCAN_MIN;
                end
            end
            S_SCAN_MIN: begin
                cmp_a = w_cand;
                cmp_b = r_best_min;
                if (w_scan_end) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (r_out_valid && out_ready) begin
                    w_state_nxt = S_LOAD;
                end
            end
            default: w_state_nxt = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf[r_count[IDX_W-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_i         <= '0;
            r_best_max  <= '0;
            r_best_min  <= '0;
            r_max_idx   <= '0;
            r_min_idx   <= '0;
            r_out_valid <= 1'b0;
            r_cmp_err   <= 1'b0;
            out_max     <= '0;
            out_min     <= '0;
            out_max_idx <= '0;
            out_min_idx <= '0;
            out_count   <= '0;
        end else begin
            if (w_scanning && w_flags_bad) begin
                r_cmp_err <= 1'b1;
            end
            case (r_state)
                S_LOAD: begin
                    if (w_accept) begin
                        r_count <= r_count + c_cnt_one;
                        r_i     <= c_idx_one;
                        // Element 0 seeds both running extremes.
                        if (r_count == '0) begin
                            r_best_max <= in_data;
                            r_best_min <= in_data;
                            r_max_idx  <= '0;
                            r_min_idx  <= '0;
                        end
                    end
                end
                S_SCAN_MAX: begin
                    if (cmp_gt) begin
                        r_best_max <= w_cand;
                        r_max_idx  <= r_i;
                    end
                    r_i <= w_scan_end ? c_idx_one : (r_i + c_idx_one);
                end
                S_SCAN_MIN: begin
                    if (cmp_lt) begin
                        r_best_min <= w_cand;
                        r_min_idx  <= r_i;
                    end
                    r_i <= r_i + c_idx_one;
                end
                S_DONE: begin
                    // First DONE cycle publishes the result; it then holds until taken.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        out_max     <= r_best_max;
                        out_min     <= r_best_min;
                        out_max_idx <= r_max_idx;
                        out_min_idx <= r_min_idx;
                        out_count   <= r_count;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_count     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
